// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle control: state enum, opcode/funct/ALUop constants
// and the packed control word. The JR state exists only when MIPS_JR_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] FUNCT_JR = 6'd8;

  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_RFMT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WRITE = 4'd4,
    S_MEM_WB    = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
`ifdef MIPS_JR_EN
    , S_JR      = 4'd12
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control-word decode for the MIPS main control FSM.
// Only the FETCH strobes and the MEM_WRITE completion look at mem_ready.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic              mem_ready_i,
  input  logic              op_legal_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_e st;
  ctrl_t  c;

  assign st = state_e'(state_i);

  always_comb begin
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.ir_write  = mem_ready_i;
        c.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        c.alu_src_b  = SRCB_IMM_SH2;
        c.alu_op     = ALUOP_ADD;
        c.illegal_op = ~op_legal_i;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = mem_ready_i;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.memto_reg  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_RFMT;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
`ifdef MIPS_JR_EN
      S_JR: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_RS;
        c.instr_done = 1'b1;
      end
`endif
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control: state register, next-state logic and reset gating of outputs.
// Optional feature: define MIPS_JR_EN to add the jr (R-type, funct 8) path.
module mips_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FW  = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUop,
  output logic           instr_done,
  output logic           illegal_op
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] dec_ctrl;
  ctrl_t             ctrl;
  logic              unused_inputs;

  // zero is consumed by the datapath's PCWriteCond gate, not here.
  assign unused_inputs = ^{zero
`ifndef MIPS_JR_EN
                           , funct
`endif
                          };

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
`ifdef MIPS_JR_EN
          // jr resolves in DECODE so the instruction completes in three cycles.
          OP_RTYPE: state_d = (funct == FUNCT_JR) ? S_JR : S_EXECUTE;
`else
          OP_RTYPE: state_d = S_EXECUTE;
`endif
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (op == OP_LW)      state_d = S_MEM_READ;
        else if (op == OP_SW) state_d = S_MEM_WRITE;
        else                  state_d = S_FETCH;
      end
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .op_legal_i  (op_legal(op)),
    .ctrl_o      (dec_ctrl)
  );

  assign ctrl = reset ? '0 : ctrl_t'(dec_ctrl);

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.memto_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUop       = ctrl.alu_op;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: each stimulus cycle queues the expected control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite;
  logic       RegDst, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUop;

  always #5 clk = ~clk;

  mips_main_control #(.OPW(6), .FW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // Control word layout: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegWrite
  // RegDst ALUSrcA ALUSrcB[2] PCSource[2] ALUop[2] instr_done illegal_op
  logic [17:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
                RegDst, ALUSrcA, ALUSrcB, PCSource, ALUop, instr_done, illegal_op};

  localparam logic [17:0] B_PCW  = 18'h1 << 17;
  localparam logic [17:0] B_PCWC = 18'h1 << 16;
  localparam logic [17:0] B_IORD = 18'h1 << 15;
  localparam logic [17:0] B_MRD  = 18'h1 << 14;
  localparam logic [17:0] B_MWR  = 18'h1 << 13;
  localparam logic [17:0] B_M2R  = 18'h1 << 12;
  localparam logic [17:0] B_IRW  = 18'h1 << 11;
  localparam logic [17:0] B_RW   = 18'h1 << 10;
  localparam logic [17:0] B_RDST = 18'h1 << 9;
  localparam logic [17:0] B_SRCA = 18'h1 << 8;
  localparam logic [17:0] SB_4   = 18'h1 << 6;
  localparam logic [17:0] SB_IMM = 18'h2 << 6;
  localparam logic [17:0] SB_SH2 = 18'h3 << 6;
  localparam logic [17:0] PS_AO  = 18'h1 << 4;
  localparam logic [17:0] PS_J   = 18'h2 << 4;
  localparam logic [17:0] PS_RS  = 18'h3 << 4;
  localparam logic [17:0] AO_SUB = 18'h1 << 2;
  localparam logic [17:0] AO_R   = 18'h2 << 2;
  localparam logic [17:0] B_DONE = 18'h1 << 1;
  localparam logic [17:0] B_ILL  = 18'h1;

  localparam logic [17:0] E_ZERO       = 18'h0;
  localparam logic [17:0] E_FETCH      = B_MRD | SB_4 | B_IRW | B_PCW;
  localparam logic [17:0] E_FETCH_WAIT = B_MRD | SB_4;
  localparam logic [17:0] E_DECODE     = SB_SH2;
  localparam logic [17:0] E_DECODE_ILL = SB_SH2 | B_ILL;
  localparam logic [17:0] E_ADDR       = B_SRCA | SB_IMM;
  localparam logic [17:0] E_MEM_READ   = B_MRD | B_IORD;
  localparam logic [17:0] E_MWR_WAIT   = B_MWR | B_IORD;
  localparam logic [17:0] E_MWR_DONE   = B_MWR | B_IORD | B_DONE;
  localparam logic [17:0] E_MEM_WB     = B_RW | B_M2R | B_DONE;
  localparam logic [17:0] E_EXECUTE    = B_SRCA | AO_R;
  localparam logic [17:0] E_R_WB       = B_RW | B_RDST | B_DONE;
  localparam logic [17:0] E_BRANCH     = B_SRCA | AO_SUB | B_PCWC | PS_AO | B_DONE;
  localparam logic [17:0] E_JUMP       = B_PCW | PS_J | B_DONE;
  localparam logic [17:0] E_ADDI_WB    = B_RW | B_DONE;
  localparam logic [17:0] E_JR         = B_PCW | PS_RS | B_DONE;

  typedef struct {
    logic [17:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  item_t it;
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      it = q.pop_front();
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", it.name, act, it.exp);
      end
    end
  end

  task automatic step(input logic r, input logic mr, input logic [5:0] o, input logic [5:0] f,
                      input logic [17:0] e, input string n);
    reset     = r;
    mem_ready = mr;
    op        = o;
    funct     = f;
    zero      = 1'($urandom);
    q.push_back('{e, n});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'd35; funct = 6'd0; zero = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 35, 0, E_ZERO, "reset_c1");
    step(1, 1, 35, 0, E_ZERO, "reset_c2");

    // lw, no wait
    step(0, 1, 35, 0, E_FETCH,    "lw_fetch");
    step(0, 1, 35, 0, E_DECODE,   "lw_decode");
    step(0, 1, 35, 0, E_ADDR,     "lw_addr");
    step(0, 1, 35, 0, E_MEM_READ, "lw_read");
    step(0, 1, 35, 0, E_MEM_WB,   "lw_wb");
    // sw, no wait
    step(0, 1, 43, 0, E_FETCH,    "sw_fetch");
    step(0, 1, 43, 0, E_DECODE,   "sw_decode");
    step(0, 1, 43, 0, E_ADDR,     "sw_addr");
    step(0, 1, 43, 0, E_MWR_DONE, "sw_write");
    // R-type add
    step(0, 1, 0, 32, E_FETCH,    "r_fetch");
    step(0, 1, 0, 32, E_DECODE,   "r_decode");
    step(0, 1, 0, 32, E_EXECUTE,  "r_execute");
    step(0, 1, 0, 32, E_R_WB,     "r_wb");
    // beq
    step(0, 1, 4, 0, E_FETCH,     "beq_fetch");
    step(0, 1, 4, 0, E_DECODE,    "beq_decode");
    step(0, 1, 4, 0, E_BRANCH,    "beq_branch");
    // j
    step(0, 1, 2, 0, E_FETCH,     "j_fetch");
    step(0, 1, 2, 0, E_DECODE,    "j_decode");
    step(0, 1, 2, 0, E_JUMP,      "j_jump");
    // fetch stalled three cycles, then addi
    for (int i = 0; i < 3; i++) step(0, 0, 8, 0, E_FETCH_WAIT, "fetch_wait");
    step(0, 1, 8, 0, E_FETCH,     "addi_fetch");
    step(0, 1, 8, 0, E_DECODE,    "addi_decode");
    step(0, 1, 8, 0, E_ADDR,      "addi_ex");
    step(0, 1, 8, 0, E_ADDI_WB,   "addi_wb");
    // illegal opcode
    step(0, 1, 63, 0, E_FETCH,      "ill_fetch");
    step(0, 1, 63, 0, E_DECODE_ILL, "ill_decode");
    // sw with two memory wait cycles
    step(0, 1, 43, 0, E_FETCH,    "swW_fetch");
    step(0, 1, 43, 0, E_DECODE,   "swW_decode");
    step(0, 1, 43, 0, E_ADDR,     "swW_addr");
    step(0, 0, 43, 0, E_MWR_WAIT, "swW_wait1");
    step(0, 0, 43, 0, E_MWR_WAIT, "swW_wait2");
    step(0, 1, 43, 0, E_MWR_DONE, "swW_write");
    // R-type with funct 8
    step(0, 1, 0, 8, E_FETCH,     "f8_fetch");
    step(0, 1, 0, 8, E_DECODE,    "f8_decode");
`ifdef MIPS_JR_EN
    step(0, 1, 0, 8, E_JR,        "jr_exec");
`else
    step(0, 1, 0, 8, E_EXECUTE,   "f8_execute");
    step(0, 1, 0, 8, E_R_WB,      "f8_wb");
`endif
    // reset while lw waits in MEM_READ
    step(0, 1, 35, 0, E_FETCH,    "rst_fetch");
    step(0, 1, 35, 0, E_DECODE,   "rst_decode");
    step(0, 1, 35, 0, E_ADDR,     "rst_addr");
    step(0, 0, 35, 0, E_MEM_READ, "rst_read_wait");
    step(1, 1, 35, 0, E_ZERO,     "rst_mid1");
    step(1, 1, 35, 0, E_ZERO,     "rst_mid2");
    step(0, 1, 35, 0, E_FETCH,    "rst_after_fetch");
    step(0, 1, 35, 0, E_DECODE,   "rst_after_decode");

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
